tcp_conn_ctrl: RTL and testbench

Single-connection passive TCP control state machine behind the TCP receive parser. It consumes parsed header fields once per received segment and tracks connection state, rcv_nxt and snd_nxt. It schedules SYN-ACK, ACK and FIN-ACK transmit requests to the TCP transmit builder over a req/grant handshake, with a retransmit timer for unacknowledged SYN-ACK and FIN-ACK.

---
 rtl/tcp_conn_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_tcp_conn_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_conn_ctrl.sv
// Passive single-connection TCP control FSM: tracks LISTEN/SYN_RCVD/ESTAB/LAST_ACK,
// rcv_nxt and snd_nxt, and issues SYN-ACK/ACK/FIN-ACK requests with retransmission.
module tcp_conn_ctrl #(
   parameter logic [15:0] LOCAL_PORT = 16'd5000,
   parameter logic [31:0] ISS        = 32'h0000_1000,
   parameter logic [23:0] RTO_CYCLES = 24'd12_500_000,
   parameter logic [1:0]  MAX_RETRY  = 2'd3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pkt_valid_i,
   input  logic        crc_ok_i,
   input  logic [15:0] src_port_i,
   input  logic [15:0] dst_port_i,
   input  logic [31:0] seq_num_i,
   input  logic [31:0] ack_num_i,
   input  logic [5:0]  tcp_flags_i,
   input  logic [15:0] payload_len_i,
   input  logic        tx_grant_i,
   output logic        tx_req_o,
   output logic [5:0]  tx_flags_o,
   output logic [31:0] tx_seq_o,
   output logic [31:0] tx_ack_o,
   output logic [15:0] tx_dst_port_o,
   output logic [1:0]  state_o,
   output logic [31:0] rcv_nxt_o,
   output logic [15:0] drop_cnt_o
);
   typedef enum logic [1:0] {LISTEN = 2'd0, SYN_RCVD = 2'd1, ESTAB = 2'd2, LAST_ACK = 2'd3} state_t;
   typedef enum logic [1:0] {KIND_SYNACK = 2'd0, KIND_ACK = 2'd1, KIND_FINACK = 2'd2} kind_t;

   localparam logic [5:0]  FLAGS_SYNACK = 6'h12;
   localparam logic [5:0]  FLAGS_ACK    = 6'h10;
   localparam logic [5:0]  FLAGS_FINACK = 6'h11;
   localparam logic [31:0] ISS_P1       = ISS + 32'd1;
   localparam logic [31:0] ISS_P2       = ISS + 32'd2;

   state_t      state_reg, state_next;
   logic [31:0] rcv_nxt_reg, rcv_nxt_next;
   logic [31:0] snd_nxt_reg, snd_nxt_next;
   logic [1:0]  retry_reg, retry_next;
   logic [15:0] remote_port_reg;
   logic [15:0] drop_cnt_reg;
   logic [23:0] timer_reg;
   logic        timer_run_reg;
   logic        pend_reg;
   kind_t       pend_kind_reg;
   logic        tx_req_reg;
   logic [5:0]  tx_flags_reg;
   logic [31:0] tx_seq_reg;
   logic [31:0] tx_ack_reg;

   logic  accept, drop, need, timer_stop, latch_port, expired;
   logic  pend_clear, timed_next, grant_done;
   kind_t need_kind;
   logic  f_ack, f_rst, f_syn, f_fin;
   logic  unused_flags;

   assign f_ack        = tcp_flags_i[4];
   assign f_rst        = tcp_flags_i[2];
   assign f_syn        = tcp_flags_i[1];
   assign f_fin        = tcp_flags_i[0];
   assign unused_flags = tcp_flags_i[5] ^ tcp_flags_i[3];

   function automatic logic [5:0] kind_flags(input kind_t k);
      case (k)
         KIND_SYNACK: return FLAGS_SYNACK;
         KIND_FINACK: return FLAGS_FINACK;
         default:     return FLAGS_ACK;
      endcase
   endfunction

   function automatic logic [31:0] kind_seq(input kind_t k, input logic [31:0] snd);
      case (k)
         KIND_SYNACK: return ISS;
         KIND_FINACK: return ISS_P1;
         default:     return snd;
      endcase
   endfunction

   // Outside LISTEN only the latched peer may talk to us.
   assign accept = pkt_valid_i & crc_ok_i & (dst_port_i == LOCAL_PORT) &
                   ((state_reg == LISTEN) | (src_port_i == remote_port_reg));
   assign expired    = timer_run_reg & (timer_reg >= RTO_CYCLES);
   assign timed_next = (state_next == SYN_RCVD) | (state_next == LAST_ACK);
   assign pend_clear = (state_next == LISTEN);
   assign grant_done = tx_req_reg & tx_grant_i;

   always_comb begin
      state_next   = state_reg;
      rcv_nxt_next = rcv_nxt_reg;
      snd_nxt_next = snd_nxt_reg;
      retry_next   = retry_reg;
      need         = 1'b0;
      need_kind    = KIND_ACK;
      drop         = pkt_valid_i & ~accept;
      timer_stop   = 1'b0;
      latch_port   = 1'b0;
      if (accept) begin
         if (f_rst && state_reg != LISTEN) begin
            state_next = LISTEN;
            timer_stop = 1'b1;
         end else begin
            case (state_reg)
               LISTEN: begin
                  if (f_syn && !f_ack && !f_rst) begin
                     latch_port   = 1'b1;
                     rcv_nxt_next = seq_num_i + 32'd1;
                     snd_nxt_next = ISS_P1;
                     retry_next   = 2'd0;
                     need         = 1'b1;
                     need_kind    = KIND_SYNACK;
                     state_next   = SYN_RCVD;
                  end else begin
                     drop = 1'b1;
                  end
               end
               SYN_RCVD: begin
                  if (f_ack && ack_num_i == ISS_P1) begin
                     state_next = ESTAB;
                     timer_stop = 1'b1;
                  end else if (f_syn && (seq_num_i + 32'd1) == rcv_nxt_reg) begin
                     need       = 1'b1;
                     need_kind  = KIND_SYNACK;
                     timer_stop = 1'b1;
                  end else begin
                     drop = 1'b1;
                  end
               end
               ESTAB: begin
                  if (seq_num_i == rcv_nxt_reg) begin
                     rcv_nxt_next = rcv_nxt_reg + {16'd0, payload_len_i} + {31'd0, f_fin};
                     if (f_fin) begin
                        need         = 1'b1;
                        need_kind    = KIND_FINACK;
                        snd_nxt_next = ISS_P2;
                        retry_next   = 2'd0;
                        state_next   = LAST_ACK;
                     end else if (payload_len_i != 16'd0) begin
                        need = 1'b1;
                     end
                  end else begin
                     need = 1'b1;
                  end
               end
               default: begin
                  if (f_ack && ack_num_i == ISS_P2) begin
                     state_next = LISTEN;
                     timer_stop = 1'b1;
                  end else begin
                     drop = 1'b1;
                  end
               end
            endcase
         end
      end else if (expired) begin
         // A segment in the same cycle takes priority; the >= compare retries next cycle.
         timer_stop = 1'b1;
         if (retry_reg < MAX_RETRY) begin
            need       = 1'b1;
            need_kind  = (state_reg == SYN_RCVD) ? KIND_SYNACK : KIND_FINACK;
            retry_next = retry_reg + 2'd1;
         end else begin
            state_next = LISTEN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= LISTEN;
         rcv_nxt_reg     <= 32'd0;
         snd_nxt_reg     <= 32'd0;
         retry_reg       <= 2'd0;
         remote_port_reg <= 16'd0;
         drop_cnt_reg    <= 16'd0;
         timer_reg       <= 24'd0;
         timer_run_reg   <= 1'b0;
         pend_reg        <= 1'b0;
         pend_kind_reg   <= KIND_SYNACK;
         tx_req_reg      <= 1'b0;
         tx_flags_reg    <= 6'd0;
         tx_seq_reg      <= 32'd0;
         tx_ack_reg      <= 32'd0;
      end else begin
         state_reg   <= state_next;
         rcv_nxt_reg <= rcv_nxt_next;
         snd_nxt_reg <= snd_nxt_next;
         retry_reg   <= retry_next;
         if (latch_port)
            remote_port_reg <= src_port_i;
         if (drop && drop_cnt_reg != 16'hFFFF)
            drop_cnt_reg <= drop_cnt_reg + 16'd1;

         // An outstanding request is never retracted; new needs coalesce into the pending slot.
         if (tx_req_reg) begin
            if (tx_grant_i)
               tx_req_reg <= 1'b0;
            if (need) begin
               pend_reg      <= 1'b1;
               pend_kind_reg <= need_kind;
            end else if (pend_clear) begin
               pend_reg <= 1'b0;
            end
         end else if (need) begin
            tx_req_reg   <= 1'b1;
            tx_flags_reg <= kind_flags(need_kind);
            tx_seq_reg   <= kind_seq(need_kind, snd_nxt_next);
            tx_ack_reg   <= rcv_nxt_next;
            pend_reg     <= 1'b0;
         end else if (pend_reg && !pend_clear) begin
            tx_req_reg   <= 1'b1;
            tx_flags_reg <= kind_flags(pend_kind_reg);
            tx_seq_reg   <= kind_seq(pend_kind_reg, snd_nxt_reg);
            tx_ack_reg   <= rcv_nxt_reg;
            pend_reg     <= 1'b0;
         end else begin
            pend_reg <= 1'b0;
         end

         if (timer_stop || !timed_next) begin
            timer_run_reg <= 1'b0;
         end else if (grant_done && (tx_flags_reg == FLAGS_SYNACK || tx_flags_reg == FLAGS_FINACK)) begin
            timer_run_reg <= 1'b1;
            timer_reg     <= 24'd0;
         end else if (timer_run_reg) begin
            timer_reg <= timer_reg + 24'd1;
         end
      end
   end

   assign tx_req_o      = tx_req_reg;
   assign tx_flags_o    = tx_flags_reg;
   assign tx_seq_o      = tx_seq_reg;
   assign tx_ack_o      = tx_ack_reg;
   assign tx_dst_port_o = remote_port_reg;
   assign state_o       = state_reg;
   assign rcv_nxt_o     = rcv_nxt_reg;
   assign drop_cnt_o    = drop_cnt_reg;
endmodule

// File: tb/tb_tcp_conn_ctrl.sv
// Scoreboard bench for tcp_conn_ctrl: expected transmit requests are queued with the
// stimulus and compared when the request rises; state/counters checked inline.
module tb_tcp_conn_ctrl;
   localparam int RTO = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pkt_valid_i = 1'b0;
   logic        crc_ok_i = 1'b0;
   logic [15:0] src_port_i = 16'd0;
   logic [15:0] dst_port_i = 16'd0;
   logic [31:0] seq_num_i = 32'd0;
   logic [31:0] ack_num_i = 32'd0;
   logic [5:0]  tcp_flags_i = 6'd0;
   logic [15:0] payload_len_i = 16'd0;
   logic        tx_grant_i = 1'b0;
   logic        tx_req_o;
   logic [5:0]  tx_flags_o;
   logic [31:0] tx_seq_o;
   logic [31:0] tx_ack_o;
   logic [15:0] tx_dst_port_o;
   logic [1:0]  state_o;
   logic [31:0] rcv_nxt_o;
   logic [15:0] drop_cnt_o;

   tcp_conn_ctrl #(
      .LOCAL_PORT(16'd5000), .ISS(32'h0000_1000), .RTO_CYCLES(24'd10), .MAX_RETRY(2'd3)
   ) dut (
      .clk(clk), .rst(rst), .pkt_valid_i(pkt_valid_i), .crc_ok_i(crc_ok_i),
      .src_port_i(src_port_i), .dst_port_i(dst_port_i), .seq_num_i(seq_num_i),
      .ack_num_i(ack_num_i), .tcp_flags_i(tcp_flags_i), .payload_len_i(payload_len_i),
      .tx_grant_i(tx_grant_i), .tx_req_o(tx_req_o), .tx_flags_o(tx_flags_o),
      .tx_seq_o(tx_seq_o), .tx_ack_o(tx_ack_o), .tx_dst_port_o(tx_dst_port_o),
      .state_o(state_o), .rcv_nxt_o(rcv_nxt_o), .drop_cnt_o(drop_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  flags;
      logic [31:0] seq;
      logic [31:0] ack;
      int          kind;   // 0 any cycle, 1 absolute cycle, 2 RTO after last grant
      int          due;
   } exp_t;

   exp_t        exp_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          last_grant_cyc = 0;
   int          grant_delay = 0;
   int          wait_cnt = 0;
   logic        grant_hold = 1'b0;
   logic        in_flight = 1'b0;
   logic        was_granted = 1'b0;
   logic [5:0]  rec_flags;
   logic [31:0] rec_seq, rec_ack;
   logic [15:0] rec_port;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [5:0] f, input logic [31:0] s, input logic [31:0] a,
                           input int kind, input int due);
      exp_t e;
      e.flags = f; e.seq = s; e.ack = a; e.kind = kind; e.due = due;
      exp_q.push_back(e);
   endtask

   task automatic send_seg(input logic crc, input logic [15:0] src, input logic [15:0] dst,
                           input logic [31:0] seq, input logic [31:0] ack,
                           input logic [5:0] flags, input logic [15:0] len);
      pkt_valid_i = 1'b1; crc_ok_i = crc; src_port_i = src; dst_port_i = dst;
      seq_num_i = seq; ack_num_i = ack; tcp_flags_i = flags; payload_len_i = len;
      $display("seg cyc=%0d src=%0d dst=%0d seq=%h ack=%h flags=%h len=%0d crc=%0b",
               cyc, src, dst, seq, ack, flags, len, crc);
      tick();
      pkt_valid_i = 1'b0; crc_ok_i = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc);
      logic idle = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         if (!tx_req_o && !in_flight && exp_q.size() == 0) begin
            idle = 1'b1;
            break;
         end
         tick();
      end
      check_val("idle_timeout", {31'd0, idle}, 32'd1);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Grant generator: grants grant_delay cycles after the request is seen.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         tx_grant_i = 1'b0;
         if (tx_req_o && !grant_hold && !rst) begin
            if (wait_cnt >= grant_delay) begin
               tx_grant_i = 1'b1;
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   // Request monitor: pops the scoreboard on each new request, checks hold stability.
   always @(negedge clk) begin
      if (rst) begin
         in_flight = 1'b0;
         was_granted = 1'b0;
      end else begin
         if (was_granted) begin
            check_val("req_drop", {31'd0, tx_req_o}, 32'd0);
            was_granted = 1'b0;
         end
         if (tx_req_o && !in_flight) begin
            $display("tx req cyc=%0d flags=%h seq=%h ack=%h port=%0d",
                     cyc, tx_flags_o, tx_seq_o, tx_ack_o, tx_dst_port_o);
            if (exp_q.size() == 0) begin
               check_val("unexpected_req", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check_val("req_flags", {26'd0, tx_flags_o}, {26'd0, e.flags});
               check_val("req_seq", tx_seq_o, e.seq);
               check_val("req_ack", tx_ack_o, e.ack);
               if (e.kind == 1)
                  check_val("req_cycle", cyc, e.due);
               else if (e.kind == 2)
                  check_val("rto_cycle", cyc, last_grant_cyc + RTO + 2);
            end
            in_flight = 1'b1;
            rec_flags = tx_flags_o; rec_seq = tx_seq_o; rec_ack = tx_ack_o; rec_port = tx_dst_port_o;
         end else if (tx_req_o && in_flight) begin
            check_val("hold_flags", {26'd0, tx_flags_o}, {26'd0, rec_flags});
            check_val("hold_seq", tx_seq_o, rec_seq);
            check_val("hold_ack", tx_ack_o, rec_ack);
            check_val("hold_port", {16'd0, tx_dst_port_o}, {16'd0, rec_port});
         end
         if (tx_req_o && tx_grant_i) begin
            in_flight = 1'b0;
            was_granted = 1'b1;
            last_grant_cyc = cyc;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      check_val("rst_state", {30'd0, state_o}, 32'd0);
      check_val("rst_req", {31'd0, tx_req_o}, 32'd0);
      check_val("rst_rcv_nxt", rcv_nxt_o, 32'd0);
      check_val("rst_drop", {16'd0, drop_cnt_o}, 32'd0);
      check_val("rst_flags", {26'd0, tx_flags_o}, 32'd0);
      rst = 1'b0;
      tick();

      // Handshake: SYN, SYN-ACK granted after 2 cycles, then ACK.
      grant_delay = 2;
      push_exp(6'h12, 32'h1000, 32'h101, 1, cyc + 1);
      send_seg(1'b1, 16'd1234, 16'd5000, 32'h100, 32'h0, 6'h02, 16'd0);
      check_val("syn_state", {30'd0, state_o}, 32'd1);
      check_val("syn_rcv_nxt", rcv_nxt_o, 32'h101);
      check_val("syn_port", {16'd0, tx_dst_port_o}, 32'd1234);
      wait_idle(20);
      send_seg(1'b1, 16'd1234, 16'd5000, 32'h101, 32'h1001, 6'h10, 16'd0);
      check_val("estab_state", {30'd0, state_o}, 32'd2);

      // Data in order, then out of order (duplicate ACK, not a drop), then pure ACK.
      push_exp(6'h10, 32'h1001, 32'h165, 1, cyc + 1);
      send_seg(1'b1, 16'd1234, 16'd5000, 32'h101, 32'h1001, 6'h18, 16'd100);
      check_val("data_rcv_nxt", rcv_nxt_o, 32'h165);
      wait_idle(20);
      push_exp(6'h10, 32'h1001, 32'h165, 1, cyc + 1);
      send_seg(1'b1, 16'd1234, 16'd5000, 32'h200, 32'h1001, 6'h18, 16'd10);
      check_val("dup_rcv_nxt", rcv_nxt_o, 32'h165);
      check_val("dup_drop", {16'd0, drop_cnt_o}, 32'd0);
      wait_idle(20);
      send_seg(1'b1, 16'd1234, 16'd5000, 32'h165, 32'h1001, 6'h10, 16'd0);
      repeat (3) tick();
      check_val("pure_ack_noreq", {31'd0, tx_req_o}, 32'd0);

      // Drops: bad CRC, wrong port, wrong peer; then saturation.
      send_seg(1'b0, 16'd1234, 16'd5000, 32'h165, 32'h1001, 6'h18, 16'd4);
      check_val("drop_crc", {16'd0, drop_cnt_o}, 32'd1);
      send_seg(1'b1, 16'd1234, 16'd80, 32'h165, 32'h1001, 6'h18, 16'd4);
      check_val("drop_dst", {16'd0, drop_cnt_o}, 32'd2);
      send_seg(1'b1, 16'd999, 16'd5000, 32'h165, 32'h1001, 6'h18, 16'd4);
      check_val("drop_src", {16'd0, drop_cnt_o}, 32'd3);
      check_val("drop_state", {30'd0, state_o}, 32'd2);
      check_val("drop_rcv_nxt", rcv_nxt_o, 32'h165);
      force dut.drop_cnt_reg = 16'hFFFD;
      #1;
      release dut.drop_cnt_reg;
      send_seg(1'b0, 16'd1234, 16'd5000, 32'h165, 32'h0, 6'h10, 16'd0);
      check_val("sat_fffe", {16'd0, drop_cnt_o}, 32'h0000_FFFE);
      send_seg(1'b0, 16'd1234, 16'd5000, 32'h165, 32'h0, 6'h10, 16'd0);
      check_val("sat_ffff", {16'd0, drop_cnt_o}, 32'h0000_FFFF);
      send_seg(1'b0, 16'd1234, 16'd5000, 32'h165, 32'h0, 6'h10, 16'd0);
      check_val("sat_hold", {16'd0, drop_cnt_o}, 32'h0000_FFFF);

      // RST, new connection near sequence wrap, FIN closes through LAST_ACK.
      send_seg(1'b1, 16'd1234, 16'd5000, 32'h165, 32'h0, 6'h04, 16'd0);
      check_val("rst_to_listen", {30'd0, state_o}, 32'd0);
      push_exp(6'h12, 32'h1000, 32'hFFFF_FFF0, 1, cyc + 1);
      send_seg(1'b1, 16'd4321, 16'd5000, 32'hFFFF_FFEF, 32'h0, 6'h02, 16'd0);
      wait_idle(20);
      send_seg(1'b1, 16'd4321, 16'd5000, 32'hFFFF_FFF0, 32'h1001, 6'h10, 16'd0);
      check_val("wrap_estab", {30'd0, state_o}, 32'd2);
      push_exp(6'h11, 32'h1001, 32'h0000_0011, 1, cyc + 1);
      send_seg(1'b1, 16'd4321, 16'd5000, 32'hFFFF_FFF0, 32'h1001, 6'h11, 16'd32);
      check_val("fin_state", {30'd0, state_o}, 32'd3);
      check_val("fin_rcv_nxt", rcv_nxt_o, 32'h0000_0011);
      wait_idle(20);
      send_seg(1'b1, 16'd4321, 16'd5000, 32'h11, 32'h1002, 6'h10, 16'd0);
      check_val("last_ack_close", {30'd0, state_o}, 32'd0);

      // Retransmit timer: three SYN-ACK resends, then abandon.
      grant_delay = 1;
      push_exp(6'h12, 32'h1000, 32'h501, 1, cyc + 1);
      for (int i = 0; i < 3; i++) push_exp(6'h12, 32'h1000, 32'h501, 2, 0);
      send_seg(1'b1, 16'd777, 16'd5000, 32'h500, 32'h0, 6'h02, 16'd0);
      for (int i = 0; i < 200; i++) begin
         if (state_o == 2'd0) break;
         tick();
      end
      check_val("rto_abandon_state", {30'd0, state_o}, 32'd0);
      check_val("rto_abandon_cycle", cyc, last_grant_cyc + RTO + 2);
      check_val("rto_queue_empty", exp_q.size(), 32'd0);

      // Grant held low: RST mid-request, fields stay put, no extra request afterwards.
      grant_hold = 1'b1;
      push_exp(6'h12, 32'h1000, 32'h901, 1, cyc + 1);
      send_seg(1'b1, 16'd55, 16'd5000, 32'h900, 32'h0, 6'h02, 16'd0);
      repeat (3) tick();
      send_seg(1'b1, 16'd55, 16'd5000, 32'h901, 32'h0, 6'h04, 16'd0);
      check_val("hold_rst_state", {30'd0, state_o}, 32'd0);
      check_val("hold_rst_req", {31'd0, tx_req_o}, 32'd1);
      send_seg(1'b1, 16'd55, 16'd5000, 32'h901, 32'h1001, 6'h18, 16'd5);
      check_val("hold_data_state", {30'd0, state_o}, 32'd0);
      check_val("hold_data_drop", {16'd0, drop_cnt_o}, 32'h0000_FFFF);
      repeat (2) tick();
      grant_hold = 1'b0;
      wait_idle(20);
      repeat (20) tick();
      check_val("after_grant_noreq", {31'd0, tx_req_o}, 32'd0);

      // Reset while an ungranted request is outstanding.
      grant_hold = 1'b1;
      push_exp(6'h12, 32'h1000, 32'h11, 1, cyc + 1);
      send_seg(1'b1, 16'd66, 16'd5000, 32'h10, 32'h0, 6'h02, 16'd0);
      repeat (2) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_val("midrst_req", {31'd0, tx_req_o}, 32'd0);
      check_val("midrst_state", {30'd0, state_o}, 32'd0);
      check_val("midrst_drop", {16'd0, drop_cnt_o}, 32'd0);
      check_val("midrst_rcv_nxt", rcv_nxt_o, 32'd0);
      grant_hold = 1'b0;
      repeat (5) tick();
      check_val("midrst_noreq", {31'd0, tx_req_o}, 32'd0);
      check_val("final_queue_empty", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
